// File: rtl/reg_file_param.sv
// reg_file_param: 1W/2R register file with a sweep clear engine; define REGFILE_BYPASS_EN for write-through read bypass
module reg_file_param #(
  parameter int DATA_W = 19,
  parameter int NUM_REGS = 16,
  parameter int ZERO_REG = 1,
  localparam int ADDR_W = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_req,
  output logic              busy,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  output logic              wr_drop,
  input  logic [ADDR_W-1:0] ra1,
  output logic [DATA_W-1:0] rd1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd2
);
  typedef enum logic {S_IDLE, S_CLEAR} state_t;
  localparam logic [ADDR_W:0] NR = (ADDR_W+1)'(NUM_REGS);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_REGS - 1);
  localparam bit ZR = ZERO_REG != 0;
  state_t r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_clr_ptr, w_clr_ptr_nxt;
  logic r_wr_drop;
  logic [DATA_W-1:0] r_regs [NUM_REGS];
  logic w_busy, w_wr_ok;
  assign w_busy = r_state == S_CLEAR;
  assign w_wr_ok = we && !w_busy && ({1'b0, wa} < NR) && !(ZR && wa == '0);
  assign busy = w_busy;
  assign wr_drop = r_wr_drop;
  function automatic logic [DATA_W-1:0] rd_of(input logic [ADDR_W-1:0] ra);
    if (w_busy || ({1'b0, ra} >= NR) || (ZR && ra == '0)) return '0;
`ifdef REGFILE_BYPASS_EN
    if (w_wr_ok && ra == wa) return wd;
`endif
    return r_regs[ra];
  endfunction
  assign rd1 = rd_of(ra1);
  assign rd2 = rd_of(ra2);
  // Sweep advances one register per cycle and returns to idle after the last one
  always_comb begin
    w_state_nxt = r_state;
    w_clr_ptr_nxt = r_clr_ptr;
    if (r_state == S_CLEAR) begin
      w_state_nxt = (r_clr_ptr == LAST) ? S_IDLE : S_CLEAR;
      w_clr_ptr_nxt = (r_clr_ptr == LAST) ? '0 : r_clr_ptr + 1'b1;
    end else begin
      w_state_nxt = clr_req ? S_CLEAR : S_IDLE;
      w_clr_ptr_nxt = '0;
    end
  end
  // Control state; reset starts a fresh sweep from register 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_CLEAR;
      r_clr_ptr <= '0;
      r_wr_drop <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_clr_ptr <= w_clr_ptr_nxt;
      r_wr_drop <= we && !w_wr_ok;
    end
  end
  // Storage is only ever zeroed by the sweep, so it carries no reset
  always_ff @(posedge clk) begin
    if (w_busy) r_regs[r_clr_ptr] <= '0;
    else if (w_wr_ok) r_regs[wa] <= wd;
  end
endmodule

// File: doc/reg_file_param.md
Name: reg_file_param

Overview:
Parametrised register file: 1 write port, 2 asynchronous read ports, configurable width and depth, optional hardwired-zero register 0.
Contains a hardware clear engine that zeroes every register one per cycle after reset or on request, with a busy indication and write-drop reporting.
Sits in the datapath as the architectural register file; the decode stage drives the read ports and the writeback stage drives the write port.

Parameters:
DATA_W, 19, register width in bits
NUM_REGS, 16, number of registers (2..256, need not be a power of 2)
ZERO_REG, 1, 1 = register 0 always reads 0 and ignores writes; 0 = register 0 is an ordinary register
ADDR_W, $clog2(NUM_REGS), address width (localparam, derived)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous, active-high reset
clr_req  in  1  single-cycle request to zero all registers
busy  out  1  high while the clear engine runs
we  in  1  write enable
wa  in  ADDR_W  write address
wd  in  DATA_W  write data
wr_drop  out  1  registered pulse: the previous-cycle write was discarded
ra1  in  ADDR_W  read address, port 1
rd1  out  DATA_W  read data, port 1 (combinational)
ra2  in  ADDR_W  read address, port 2
rd2  out  DATA_W  read data, port 2 (combinational)

Behaviour:
- FSM states: IDLE, CLEAR. Clear pointer clr_ptr is ADDR_W bits wide.
- Reset asserted (asynchronous):
  - state = CLEAR, clr_ptr = 0, busy = 1, wr_drop = 0.
  - Register contents are not reset directly; they are zeroed by the clear engine.
- CLEAR state, each cycle:
  - reg[clr_ptr] <= 0, then clr_ptr increments.
  - When clr_ptr == NUM_REGS-1, that last register is written and the next state is IDLE.
  - busy stays high for exactly NUM_REGS cycles after reset release, or after the cycle that accepts clr_req.
- IDLE state:
  - clr_req = 1 -> CLEAR next cycle, clr_ptr = 0, busy rises on the next edge.
  - clr_req received while already in CLEAR is ignored; the sweep does not restart.
- Write: on the rising edge with we=1, busy=0, wa < NUM_REGS, and not (ZERO_REG=1 and wa=0), reg[wa] <= wd.
  - Any other write with we=1 is discarded, and wr_drop = 1 on the following cycle only.
  - If clr_req and we arrive in the same IDLE cycle, the write is performed; the subsequent sweep zeroes it.
- Read, combinational:
  - rdN = 0 if busy=1, raN >= NUM_REGS, or (ZERO_REG=1 and raN=0).
  - Otherwise rdN = reg[raN].
  - Both ports may address the same register.
- Read-after-write timing without bypass: a read of the register being written in the same cycle returns the old value; the new value is visible the cycle after the edge.
- Reset mid-clear: the sweep restarts from 0. Reset mid-write: the write is lost.
- All arithmetic is unsigned. clr_ptr never exceeds NUM_REGS-1.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: write-through bypass. If a write would be accepted this cycle (same conditions as above) and raN == wa, then rdN = wd combinationally in that cycle. Both ports are bypassed independently. Discarded writes are never bypassed.
- Not defined: no bypass; same-cycle reads return the old register value.

Test Plan:
1. Reset clear: assert rst for 3 cycles, release -> busy = 1 for exactly 16 cycles, then 0; afterwards ra1=5 gives rd1=0 and ra2=15 gives rd2=0.
2. Write/read: after clear, we=1, wa=3, wd=19'h7ABCD; next cycle ra1=3 -> rd1=19'h7ABCD, wr_drop=0. Write to wa=0 with wd=19'h1 -> wr_drop=1 next cycle; ra2=0 -> rd2=0.
3. Write during busy: clr_req pulse, then we=1, wa=4, wd=19'h00055 in the next cycle -> wr_drop=1 the cycle after; once busy=0, reg 4 reads 0.
4. clr_req mid-sweep: second clr_req 5 cycles into CLEAR -> busy still deasserts 16 cycles after the first request.
5. Same-cycle read/write: wa=ra1=7, wd=19'h12345, reg 7 previously 19'h00011 -> rd1=19'h00011 without REGFILE_BYPASS_EN, rd1=19'h12345 with it; rd1=19'h12345 after the edge in both builds.
6. Out-of-range access with NUM_REGS=12: write wa=13 -> wr_drop=1 next cycle, no register changes; read ra1=13 -> rd1=0.
